conv2d_stream_engine: RTL

Parametrised streaming 2D convolution engine. It is the successor to the fixed 3x3 core, adding:
- runtime-loadable signed coefficients
- configurable image size
- rounding, shift, ReLU and saturation on the output
- full ready/valid backpressure and frame last/done signalling

It sits between the pixel source and the downstream pooling/writeback stage. Each frame is one single-channel image; only windows lying fully inside the image are computed, with stride 1.

---
 rtl/conv_pkg.sv | 48 ++++
 rtl/conv_window_gen.sv | 88 ++++++++
 rtl/conv2d_stream_engine.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming 2D convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN
  } state_t;

  // Ceiling log2 for widths; clog2(1) == 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Accumulator width that holds the sum of K*K full-scale products without overflow.
  function automatic int acc_w(input int dw, input int cw, input int k);
    return dw + cw + 1 + clog2(k * k);
  endfunction

  // Round-half-up, arithmetic right shift, optional ReLU, then clamp to a dw-bit signed range.
  function automatic logic signed [63:0] quantise(input logic signed [63:0] sum,
                                                  input logic [31:0] shift,
                                                  input logic relu,
                                                  input int dw);
    logic signed [63:0] v;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    v = sum;
    if (shift != 32'd0) v = v + (64'sd1 <<< (shift - 32'd1));
    v = v >>> shift;
    if (relu && (v < 64'sd0)) v = 64'sd0;
    max_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (dw - 1));
    if (v > max_v) v = max_v;
    else if (v < min_v) v = min_v;
    return v;
  endfunction

endpackage

// File: rtl/conv_window_gen.sv
// Line buffers plus KxK sliding window; flags windows lying fully inside the image.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         clr,
  input  logic                                         en,
  input  logic                                         adv,
  input  logic [DATA_WIDTH-1:0]                        pix,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] win,
  output logic                                         win_valid,
  output logic                                         win_last
);
  localparam int K     = KERNEL_SIZE;
  localparam int COL_W = (clog2(IMG_WIDTH) < 1) ? 1 : clog2(IMG_WIDTH);
  localparam int ROW_W = (clog2(IMG_HEIGHT) < 1) ? 1 : clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] MIN_COL  = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] MIN_ROW  = ROW_W'(K - 1);

  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [DATA_WIDTH-1:0] line_buf [K-1][IMG_WIDTH];
  logic [DATA_WIDTH-1:0] win_r    [K][K];
  logic [DATA_WIDTH-1:0] col_in   [K];

  // New window column: current pixel at the bottom, same column of older rows above it.
  always_comb begin
    for (int r = 0; r < K; r++) col_in[r] = '0;
    col_in[K-1] = pix;
    for (int r = 0; r < K - 1; r++) col_in[r] = line_buf[K-2-r][IMG_WIDTH-1];
  end

  // Shift line buffers and window per accepted pixel; valid drops on a pipeline bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      for (int j = 0; j < K - 1; j++)
        for (int i = 0; i < IMG_WIDTH; i++) line_buf[j][i] <= '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win_r[r][c] <= '0;
    end else if (clr) begin
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else if (en) begin
      for (int j = 0; j < K - 1; j++) begin
        line_buf[j][0] <= (j == 0) ? pix : line_buf[(j == 0) ? 0 : j-1][IMG_WIDTH-1];
        for (int i = 1; i < IMG_WIDTH; i++) line_buf[j][i] <= line_buf[j][i-1];
      end
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_r[r][c] <= win_r[r][c+1];
        win_r[r][K-1] <= col_in[r];
      end
      win_valid <= (row >= MIN_ROW) && (col >= MIN_COL);
      win_last  <= (row == LAST_ROW) && (col == LAST_COL);
      if (col == LAST_COL) begin
        col <= '0;
        if (row != LAST_ROW) row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end else if (adv) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end
  end

  // Flatten window in raster order, tap index r*K+c.
  always_comb begin
    win = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        win[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = win_r[r][c];
  end

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming KxK convolution: control FSM, coefficient bank, MAC and quantise stages.
module conv2d_stream_engine
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int COEF_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_load,
  input  logic                         coef_valid,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  output logic                         coef_ready,
  input  logic                         start,
  input  logic [SHIFT_WIDTH-1:0]       cfg_shift,
  input  logic                         cfg_relu,
  input  logic                         s_valid,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         s_ready,
  output logic                         m_valid,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_last,
  input  logic                         m_ready,
  output logic                         busy,
  output logic                         done
);
  localparam int K      = KERNEL_SIZE;
  localparam int NTAP   = K * K;
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH + 1;
  localparam int ACC_W  = acc_w(DATA_WIDTH, COEF_WIDTH, K);
  localparam int IDX_W  = clog2(NTAP);
  localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT;
  localparam int PCNT_W = clog2(NPIX);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NTAP - 1);
  localparam logic [PCNT_W-1:0] LAST_PIX = PCNT_W'(NPIX - 1);

  state_t                         state;
  logic [IDX_W-1:0]               coef_idx;
  logic [PCNT_W-1:0]              pix_cnt;
  logic [SHIFT_WIDTH-1:0]         shift_q;
  logic                           relu_q;
  logic signed [COEF_WIDTH-1:0]   coef [NTAP];
  logic                           adv;
  logic                           accept;
  logic                           win_clr;
  logic [NTAP*DATA_WIDTH-1:0]     win;
  logic                           win_valid;
  logic                           win_last;
  logic signed [PROD_W-1:0]       prod [NTAP];
  logic                           v1;
  logic                           l1;
  logic signed [ACC_W-1:0]        sum;
  logic [DATA_WIDTH-1:0]          q_data;

  assign adv     = !m_valid || m_ready;
  assign s_ready = (state == RUN) && adv;
  assign accept  = s_valid && s_ready;
  assign win_clr = (state == IDLE) && start;

  // Sequencing: coefficient load, frame run, drain to empty, done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      coef_idx   <= '0;
      pix_cnt    <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      coef_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            pix_cnt <= '0;
            shift_q <= cfg_shift;
            relu_q  <= cfg_relu;
          end else if (cfg_load) begin
            state      <= LOAD;
            busy       <= 1'b1;
            coef_ready <= 1'b1;
            coef_idx   <= '0;
          end
        end
        LOAD: begin
          if (coef_valid) begin
            coef_idx <= coef_idx + 1'b1;
            if (coef_idx == LAST_IDX) begin
              state      <= IDLE;
              busy       <= 1'b0;
              coef_ready <= 1'b0;
            end
          end
        end
        RUN: begin
          if (accept) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (pix_cnt == LAST_PIX) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!win_valid && !v1 && adv) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Coefficient bank, written in raster order while loading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAP; i++) coef[i] <= '0;
    end else if (coef_ready && coef_valid) begin
      coef[coef_idx] <= coef_data;
    end
  end

  conv_window_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .KERNEL_SIZE(KERNEL_SIZE),
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (win_clr),
    .en       (accept),
    .adv      (adv),
    .pix      (s_data),
    .win      (win),
    .win_valid(win_valid),
    .win_last (win_last)
  );

  // Products of signed coefficients with zero-extended pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
      for (int i = 0; i < NTAP; i++) prod[i] <= '0;
    end else if (adv) begin
      v1 <= win_valid;
      l1 <= win_last;
      for (int i = 0; i < NTAP; i++)
        prod[i] <= PROD_W'(coef[i]) * PROD_W'($signed({1'b0, win[i*DATA_WIDTH +: DATA_WIDTH]}));
    end
  end

  // Adder tree and quantisation to the output width.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NTAP; i++) sum = sum + ACC_W'(prod[i]);
    q_data = DATA_WIDTH'(quantise(64'(sum), 32'(shift_q), relu_q, DATA_WIDTH));
  end

  // Output register; held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else if (adv) begin
      m_valid <= v1;
      m_last  <= v1 && l1;
      if (v1) m_data <= q_data;
    end
  end

endmodule
